// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter that shares one burst-memory controller port between two
// write channels and two read channels, with one burst in flight at a time.
module mem_burst_arbiter #(
   parameter int MEM_DATA_BITS  = 64,
   parameter int ADDR_BITS      = 24,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   input  logic                     local_init_done,
   input  logic                     wr0_burst_req,
   input  logic [9:0]               wr0_burst_len,
   input  logic [ADDR_BITS-1:0]     wr0_burst_addr,
   input  logic [MEM_DATA_BITS-1:0] wr0_burst_data,
   output logic                     wr0_burst_data_req,
   output logic                     wr0_burst_finish,
   input  logic                     wr1_burst_req,
   input  logic [9:0]               wr1_burst_len,
   input  logic [ADDR_BITS-1:0]     wr1_burst_addr,
   input  logic [MEM_DATA_BITS-1:0] wr1_burst_data,
   output logic                     wr1_burst_data_req,
   output logic                     wr1_burst_finish,
   input  logic                     rd0_burst_req,
   input  logic [9:0]               rd0_burst_len,
   input  logic [ADDR_BITS-1:0]     rd0_burst_addr,
   output logic [MEM_DATA_BITS-1:0] rd0_burst_data,
   output logic                     rd0_burst_data_valid,
   output logic                     rd0_burst_finish,
   input  logic                     rd1_burst_req,
   input  logic [9:0]               rd1_burst_len,
   input  logic [ADDR_BITS-1:0]     rd1_burst_addr,
   output logic [MEM_DATA_BITS-1:0] rd1_burst_data,
   output logic                     rd1_burst_data_valid,
   output logic                     rd1_burst_finish,
   output logic                     wr_burst_req,
   output logic [9:0]               wr_burst_len,
   output logic [ADDR_BITS-1:0]     wr_burst_addr,
   output logic [MEM_DATA_BITS-1:0] wr_burst_data,
   input  logic                     wr_burst_data_req,
   input  logic                     wr_burst_finish,
   output logic                     rd_burst_req,
   output logic [9:0]               rd_burst_len,
   output logic [ADDR_BITS-1:0]     rd_burst_addr,
   input  logic                     rd_burst_data_valid,
   input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
   input  logic                     rd_burst_finish,
   output logic [1:0]               grant,
   output logic                     busy,
   output logic                     timeout_err
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_ZERO = 2'd2} state_t;

   localparam logic [11:0] TIMEOUT_LIM = 12'(TIMEOUT_CYCLES);

   state_t               state_r;
   logic [1:0]           grant_r;
   logic [1:0]           ptr_r;
   logic                 wr_req_r;
   logic                 rd_req_r;
   logic [9:0]           wr_len_r;
   logic [9:0]           rd_len_r;
   logic [ADDR_BITS-1:0] wr_addr_r;
   logic [ADDR_BITS-1:0] rd_addr_r;
   logic [11:0]          wd_cnt_r;
   logic                 timeout_err_r;

   logic [3:0]           req_vec_s;
   logic [2:0]           pick_s;
   logic [9:0]           len_sel_s;
   logic [ADDR_BITS-1:0] addr_sel_s;
   logic                 busy_s;
   logic                 fin_match_s;
   logic                 chan_fin_s;
   logic [11:0]          wd_next_s;

   // Highest priority is the channel right after ptr; returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
      logic [2:0] res;
      logic [1:0] cand;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         cand = ptr + k[1:0];
         res  = req[cand] ? {1'b1, cand} : res;
      end
      return res;
   endfunction

   assign req_vec_s   = {rd1_burst_req, rd0_burst_req, wr1_burst_req, wr0_burst_req};
   assign pick_s      = rr_pick(ptr_r, req_vec_s);
   assign busy_s      = (state_r == ST_BUSY);
   assign fin_match_s = busy_s && local_init_done &&
                        (grant_r[1] ? rd_burst_finish : wr_burst_finish);
   assign chan_fin_s  = fin_match_s || (state_r == ST_ZERO);
   assign wd_next_s   = (wd_cnt_r == 12'hFFF) ? wd_cnt_r : wd_cnt_r + 12'd1;

   // Length/address of the channel the arbiter would grant this cycle.
   always_comb begin
      len_sel_s  = 10'd0;
      addr_sel_s = {ADDR_BITS{1'b0}};
      case (pick_s[1:0])
         2'd0:    begin len_sel_s = wr0_burst_len; addr_sel_s = wr0_burst_addr; end
         2'd1:    begin len_sel_s = wr1_burst_len; addr_sel_s = wr1_burst_addr; end
         2'd2:    begin len_sel_s = rd0_burst_len; addr_sel_s = rd0_burst_addr; end
         2'd3:    begin len_sel_s = rd1_burst_len; addr_sel_s = rd1_burst_addr; end
         default: begin len_sel_s = 10'd0; addr_sel_s = {ADDR_BITS{1'b0}}; end
      endcase
   end

   // Write data mux toward the controller; zero unless a write burst is in flight.
   always_comb begin
      wr_burst_data = {MEM_DATA_BITS{1'b0}};
      if (busy_s && (grant_r == 2'd0)) begin
         wr_burst_data = wr0_burst_data;
      end else if (busy_s && (grant_r == 2'd1)) begin
         wr_burst_data = wr1_burst_data;
      end else begin
         wr_burst_data = {MEM_DATA_BITS{1'b0}};
      end
   end

   // Arbitration FSM, controller request registers and watchdog.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         grant_r       <= 2'd0;
         ptr_r         <= 2'd3;
         wr_req_r      <= 1'b0;
         rd_req_r      <= 1'b0;
         wr_len_r      <= 10'd0;
         rd_len_r      <= 10'd0;
         wr_addr_r     <= {ADDR_BITS{1'b0}};
         rd_addr_r     <= {ADDR_BITS{1'b0}};
         wd_cnt_r      <= 12'd0;
         timeout_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               wd_cnt_r <= 12'd0;
               if (local_init_done && pick_s[2]) begin
                  grant_r <= pick_s[1:0];
                  if (pick_s[1]) begin
                     rd_len_r  <= len_sel_s;
                     rd_addr_r <= addr_sel_s;
                  end else begin
                     wr_len_r  <= len_sel_s;
                     wr_addr_r <= addr_sel_s;
                  end
                  if (len_sel_s != 10'd0) begin
                     wr_req_r <= ~pick_s[1];
                     rd_req_r <= pick_s[1];
                     state_r  <= ST_BUSY;
                  end else begin
                     state_r  <= ST_ZERO;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               wd_cnt_r <= wd_next_s;
               if (wd_next_s == TIMEOUT_LIM) begin
                  timeout_err_r <= 1'b1;
               end
               // Losing memory init aborts silently; ptr is kept so the same channel resumes.
               if (!local_init_done) begin
                  wr_req_r <= 1'b0;
                  rd_req_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end else if (fin_match_s) begin
                  wr_req_r <= 1'b0;
                  rd_req_r <= 1'b0;
                  ptr_r    <= grant_r;
                  state_r  <= ST_IDLE;
               end else begin
                  state_r  <= ST_BUSY;
               end
            end
            ST_ZERO: begin
               wd_cnt_r <= 12'd0;
               ptr_r    <= grant_r;
               state_r  <= ST_IDLE;
            end
            default: begin
               wr_req_r <= 1'b0;
               rd_req_r <= 1'b0;
               wd_cnt_r <= 12'd0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr_burst_req  = wr_req_r;
   assign rd_burst_req  = rd_req_r;
   assign wr_burst_len  = wr_len_r;
   assign rd_burst_len  = rd_len_r;
   assign wr_burst_addr = wr_addr_r;
   assign rd_burst_addr = rd_addr_r;
   assign grant         = grant_r;
   assign busy          = busy_s;
   assign timeout_err   = timeout_err_r;

   assign wr0_burst_data_req   = busy_s && (grant_r == 2'd0) && wr_burst_data_req;
   assign wr1_burst_data_req   = busy_s && (grant_r == 2'd1) && wr_burst_data_req;
   assign rd0_burst_data_valid = busy_s && (grant_r == 2'd2) && rd_burst_data_valid;
   assign rd1_burst_data_valid = busy_s && (grant_r == 2'd3) && rd_burst_data_valid;
   assign rd0_burst_data       = rd_burst_data;
   assign rd1_burst_data       = rd_burst_data;

   assign wr0_burst_finish = chan_fin_s && (grant_r == 2'd0);
   assign wr1_burst_finish = chan_fin_s && (grant_r == 2'd1);
   assign rd0_burst_finish = chan_fin_s && (grant_r == 2'd2);
   assign rd1_burst_finish = chan_fin_s && (grant_r == 2'd3);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter; the bench plays both the requesters
// and the memory controller.
module tb_mem_burst_arbiter;

   logic        mem_clk;
   logic        rst_n;
   logic        local_init_done;
   logic        wr0_burst_req, wr1_burst_req, rd0_burst_req, rd1_burst_req;
   logic [9:0]  wr0_burst_len, wr1_burst_len, rd0_burst_len, rd1_burst_len;
   logic [23:0] wr0_burst_addr, wr1_burst_addr, rd0_burst_addr, rd1_burst_addr;
   logic [63:0] wr0_burst_data, wr1_burst_data;
   logic        wr0_burst_data_req, wr1_burst_data_req;
   logic        wr0_burst_finish, wr1_burst_finish, rd0_burst_finish, rd1_burst_finish;
   logic [63:0] rd0_burst_data, rd1_burst_data;
   logic        rd0_burst_data_valid, rd1_burst_data_valid;
   logic        wr_burst_req, rd_burst_req;
   logic [9:0]  wr_burst_len, rd_burst_len;
   logic [23:0] wr_burst_addr, rd_burst_addr;
   logic [63:0] wr_burst_data, rd_burst_data;
   logic        wr_burst_data_req, rd_burst_data_valid;
   logic        wr_burst_finish, rd_burst_finish;
   logic [1:0]  grant;
   logic        busy;
   logic        timeout_err;
   logic [3:0]  fin_vec;

   int checks   = 0;
   int failures = 0;

   assign fin_vec = {rd1_burst_finish, rd0_burst_finish, wr1_burst_finish, wr0_burst_finish};

   mem_burst_arbiter #(
      .MEM_DATA_BITS (64),
      .ADDR_BITS     (24),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .mem_clk             (mem_clk),
      .rst_n               (rst_n),
      .local_init_done     (local_init_done),
      .wr0_burst_req       (wr0_burst_req),
      .wr0_burst_len       (wr0_burst_len),
      .wr0_burst_addr      (wr0_burst_addr),
      .wr0_burst_data      (wr0_burst_data),
      .wr0_burst_data_req  (wr0_burst_data_req),
      .wr0_burst_finish    (wr0_burst_finish),
      .wr1_burst_req       (wr1_burst_req),
      .wr1_burst_len       (wr1_burst_len),
      .wr1_burst_addr      (wr1_burst_addr),
      .wr1_burst_data      (wr1_burst_data),
      .wr1_burst_data_req  (wr1_burst_data_req),
      .wr1_burst_finish    (wr1_burst_finish),
      .rd0_burst_req       (rd0_burst_req),
      .rd0_burst_len       (rd0_burst_len),
      .rd0_burst_addr      (rd0_burst_addr),
      .rd0_burst_data      (rd0_burst_data),
      .rd0_burst_data_valid(rd0_burst_data_valid),
      .rd0_burst_finish    (rd0_burst_finish),
      .rd1_burst_req       (rd1_burst_req),
      .rd1_burst_len       (rd1_burst_len),
      .rd1_burst_addr      (rd1_burst_addr),
      .rd1_burst_data      (rd1_burst_data),
      .rd1_burst_data_valid(rd1_burst_data_valid),
      .rd1_burst_finish    (rd1_burst_finish),
      .wr_burst_req        (wr_burst_req),
      .wr_burst_len        (wr_burst_len),
      .wr_burst_addr       (wr_burst_addr),
      .wr_burst_data       (wr_burst_data),
      .wr_burst_data_req   (wr_burst_data_req),
      .wr_burst_finish     (wr_burst_finish),
      .rd_burst_req        (rd_burst_req),
      .rd_burst_len        (rd_burst_len),
      .rd_burst_addr       (rd_burst_addr),
      .rd_burst_data_valid (rd_burst_data_valid),
      .rd_burst_data       (rd_burst_data),
      .rd_burst_finish     (rd_burst_finish),
      .grant               (grant),
      .busy                (busy),
      .timeout_err         (timeout_err)
   );

   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Grant edge, controller finish, then the mandatory idle cycle.
   task automatic run_burst(input logic [1:0] g);
      tick();
      chk("grant", 64'(grant), 64'(g));
      chk("busy_on", 64'(busy), 64'd1);
      chk("wr_req_side", 64'(wr_burst_req), 64'(!g[1]));
      chk("rd_req_side", 64'(rd_burst_req), 64'(g[1]));
      if (g[1]) rd_burst_finish = 1'b1;
      else      wr_burst_finish = 1'b1;
      settle();
      chk("chan_finish", 64'(fin_vec), 64'(4'b0001 << g));
      tick();
      wr_burst_finish = 1'b0;
      rd_burst_finish = 1'b0;
      case (g)
         2'd0:    wr0_burst_req = 1'b0;
         2'd1:    wr1_burst_req = 1'b0;
         2'd2:    rd0_burst_req = 1'b0;
         default: rd1_burst_req = 1'b0;
      endcase
      settle();
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_wr_req", 64'(wr_burst_req), 64'd0);
      chk("idle_rd_req", 64'(rd_burst_req), 64'd0);
      chk("idle_finish", 64'(fin_vec), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      local_init_done = 1'b1;
      {wr0_burst_req, wr1_burst_req, rd0_burst_req, rd1_burst_req} = 4'b0000;
      {wr0_burst_len, wr1_burst_len, rd0_burst_len, rd1_burst_len} = {4{10'd0}};
      {wr0_burst_addr, wr1_burst_addr, rd0_burst_addr, rd1_burst_addr} = {4{24'd0}};
      wr0_burst_data = 64'd0;
      wr1_burst_data = 64'd0;
      wr_burst_data_req = 1'b0;
      rd_burst_data_valid = 1'b0;
      rd_burst_data = 64'd0;
      wr_burst_finish = 1'b0;
      rd_burst_finish = 1'b0;

      // Reset values
      #12;
      chk("rst_wr_req", 64'(wr_burst_req), 64'd0);
      chk("rst_rd_req", 64'(rd_burst_req), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_timeout", 64'(timeout_err), 64'd0);
      chk("rst_wr_data", wr_burst_data, 64'd0);
      tick();
      rst_n = 1'b1;

      // Single wr0 burst, len 16 at 0x000100
      wr0_burst_req  = 1'b1;
      wr0_burst_len  = 10'd16;
      wr0_burst_addr = 24'h000100;
      wr0_burst_data = 64'h0000_0000_0000_00A5;
      settle();
      chk("t1_pre_req", 64'(wr_burst_req), 64'd0);
      tick();
      chk("t1_wr_req", 64'(wr_burst_req), 64'd1);
      chk("t1_wr_len", 64'(wr_burst_len), 64'd16);
      chk("t1_wr_addr", 64'(wr_burst_addr), 64'h100);
      chk("t1_grant", 64'(grant), 64'd0);
      wr_burst_data_req = 1'b1;
      settle();
      chk("t1_wr0_dreq", 64'(wr0_burst_data_req), 64'd1);
      chk("t1_wr1_dreq", 64'(wr1_burst_data_req), 64'd0);
      chk("t1_wr_data", wr_burst_data, 64'hA5);
      tick();
      wr_burst_data_req = 1'b0;
      settle();
      chk("t1_wr0_dreq_off", 64'(wr0_burst_data_req), 64'd0);
      wr_burst_finish = 1'b1;
      settle();
      chk("t1_finish", 64'(fin_vec), 64'b0001);
      tick();
      wr_burst_finish = 1'b0;
      wr0_burst_req = 1'b0;
      settle();
      chk("t1_finish_one", 64'(fin_vec), 64'd0);
      chk("t1_req_clear", 64'(wr_burst_req), 64'd0);
      chk("t1_busy_clear", 64'(busy), 64'd0);

      // Fresh reset so the pointer is back to 3, then wr0/rd0/rd1 contend
      rst_n = 1'b0;
      settle();
      rst_n = 1'b1;
      wr0_burst_req = 1'b1; wr0_burst_len = 10'd4; wr0_burst_addr = 24'h000200;
      rd0_burst_req = 1'b1; rd0_burst_len = 10'd4; rd0_burst_addr = 24'h000300;
      rd1_burst_req = 1'b1; rd1_burst_len = 10'd4; rd1_burst_addr = 24'h000400;
      run_burst(2'd0);
      run_burst(2'd2);
      chk("t2_rd0_addr", 64'(rd_burst_addr), 64'h300);
      run_burst(2'd3);
      chk("t2_rd1_addr", 64'(rd_burst_addr), 64'h400);

      // Zero-length rd1: finish in the cycle after the request is sampled
      rd1_burst_req = 1'b1;
      rd1_burst_len = 10'd0;
      settle();
      chk("t3_no_early_fin", 64'(fin_vec), 64'd0);
      tick();
      chk("t3_zero_fin", 64'(fin_vec), 64'b1000);
      chk("t3_no_rd_req", 64'(rd_burst_req), 64'd0);
      chk("t3_zero_busy", 64'(busy), 64'd0);
      rd1_burst_req = 1'b0;
      tick();
      chk("t3_fin_gone", 64'(fin_vec), 64'd0);
      chk("t3_rd_req_after", 64'(rd_burst_req), 64'd0);

      // rd0 burst ignores a stray write finish; read data routing
      rd0_burst_req = 1'b1;
      rd0_burst_len = 10'd8;
      tick();
      chk("t4_grant", 64'(grant), 64'd2);
      rd_burst_data_valid = 1'b1;
      rd_burst_data = 64'hDEAD_BEEF_0000_0001;
      wr_burst_data_req = 1'b1;
      settle();
      chk("t4_rd0_valid", 64'(rd0_burst_data_valid), 64'd1);
      chk("t4_rd1_valid", 64'(rd1_burst_data_valid), 64'd0);
      chk("t4_rd1_bcast", rd1_burst_data, 64'hDEAD_BEEF_0000_0001);
      chk("t4_wr0_dreq_blocked", 64'(wr0_burst_data_req), 64'd0);
      rd_burst_data_valid = 1'b0;
      wr_burst_data_req = 1'b0;
      wr_burst_finish = 1'b1;
      settle();
      chk("t4_stray_fin", 64'(fin_vec), 64'd0);
      tick();
      wr_burst_finish = 1'b0;
      settle();
      chk("t4_still_grant", 64'(grant), 64'd2);
      chk("t4_still_busy", 64'(busy), 64'd1);
      chk("t4_still_rd_req", 64'(rd_burst_req), 64'd1);
      rd_burst_finish = 1'b1;
      settle();
      chk("t4_fin", 64'(fin_vec), 64'b0100);
      tick();
      rd_burst_finish = 1'b0;
      rd0_burst_req = 1'b0;
      settle();
      chk("t4_idle", 64'(busy), 64'd0);

      // init_done drop mid rd1 burst; rd1 must win again over a new wr0 request
      rd1_burst_req = 1'b1;
      rd1_burst_len = 10'd12;
      rd1_burst_addr = 24'h000500;
      tick();
      chk("t5_grant", 64'(grant), 64'd3);
      chk("t5_rd_req", 64'(rd_burst_req), 64'd1);
      local_init_done = 1'b0;
      settle();
      chk("t5_no_fin", 64'(fin_vec), 64'd0);
      tick();
      chk("t5_abort_req", 64'(rd_burst_req), 64'd0);
      chk("t5_abort_busy", 64'(busy), 64'd0);
      chk("t5_abort_fin", 64'(fin_vec), 64'd0);
      tick();
      chk("t5_hold_idle", 64'(busy), 64'd0);
      wr0_burst_req = 1'b1;
      wr0_burst_len = 10'd3;
      local_init_done = 1'b1;
      run_burst(2'd3);
      chk("t5_rd_len", 64'(rd_burst_len), 64'd12);
      run_burst(2'd0);

      // Watchdog: controller never finishes wr1
      wr1_burst_req = 1'b1;
      wr1_burst_len = 10'd5;
      wr1_burst_data = 64'h1111;
      tick();
      chk("t6_grant", 64'(grant), 64'd1);
      chk("t6_wr_data", wr_burst_data, 64'h1111);
      repeat (19) tick();
      chk("t6_no_timeout_19", 64'(timeout_err), 64'd0);
      tick();
      chk("t6_timeout_20", 64'(timeout_err), 64'd1);
      chk("t6_still_busy", 64'(busy), 64'd1);
      local_init_done = 1'b0;
      tick();
      chk("t6_abort_busy", 64'(busy), 64'd0);
      chk("t6_sticky_idle", 64'(timeout_err), 64'd1);
      local_init_done = 1'b1;
      tick();
      chk("t6_regrant", 64'(busy), 64'd1);
      chk("t6_sticky_busy", 64'(timeout_err), 64'd1);

      // Async reset mid-burst
      #3;
      rst_n = 1'b0;
      settle();
      chk("t7_busy", 64'(busy), 64'd0);
      chk("t7_wr_req", 64'(wr_burst_req), 64'd0);
      chk("t7_grant", 64'(grant), 64'd0);
      chk("t7_timeout", 64'(timeout_err), 64'd0);
      wr1_burst_req = 1'b0;
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
